// File: rtl/multibyte_add_seq_if.sv
// Bus interface for multibyte_add_seq: request/operand inputs and result outputs.
// Optional macro MULTIBYTE_ADD_SUB_EN adds the 'sub' request field.
interface multibyte_add_seq_if #(
  parameter int NBYTES = 4
) ();
  localparam int W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef MULTIBYTE_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

`ifdef MULTIBYTE_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/multibyte_add_seq.sv
// Sequential multi-byte adder: one 8-bit ripple add per clock, carry chained
// through a register, result bytes collected into a W-bit sum.
// Optional macro MULTIBYTE_ADD_SUB_EN: adds a 'sub' request (a - b via ~b + 1).
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multibyte_add_seq_if.slave   bus
);
  localparam int W       = 8 * NBYTES;
  localparam int IDXW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LASTIDX = IDXW'(NBYTES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic            w_accept;
  logic            w_lastByte;

  logic [W-1:0]    r_aReg;
  logic [W-1:0]    r_bReg;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_done;

  logic [7:0]      w_aByte;
  logic [7:0]      w_bByte;
  logic [8:0]      w_addFull;
  logic [W-1:0]    w_bEff;
  logic            w_cinEff;

  // Operand B and byte-0 carry as seen by the adder (inverted/forced for subtract)
`ifdef MULTIBYTE_ADD_SUB_EN
  assign w_bEff   = bus.sub ? ~bus.b : bus.b;
  assign w_cinEff = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_bEff   = bus.b;
  assign w_cinEff = bus.cin;
`endif

  // The single shared 8-bit adder slice working on byte r_idx
  assign w_aByte   = r_aReg[{r_idx, 3'b000} +: 8];
  assign w_bByte   = r_bReg[{r_idx, 3'b000} +: 8];
  assign w_addFull = {1'b0, w_aByte} + {1'b0, w_bByte} + {8'b0, r_carry};

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // Next-state logic: accept start only in IDLE, leave RUN after the top byte
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_lastByte  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (r_idx == LASTIDX) begin
          w_lastByte  = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then store one sum byte per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aReg  <= '0;
      r_bReg  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_aReg  <= bus.a;
        r_bReg  <= w_bEff;
        r_carry <= w_cinEff;
        r_idx   <= '0;
        r_sum   <= '0;
      end else if (r_state == RUN) begin
        r_sum[{r_idx, 3'b000} +: 8] <= w_addFull[7:0];
        r_carry <= w_addFull[8];
        r_idx   <= r_idx + 1'b1;
        if (w_lastByte) begin
          r_cout <= w_addFull[8];
          r_ovf  <= r_aReg[W-1] ^ r_bReg[W-1] ^ w_addFull[7] ^ w_addFull[8];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed self-checking bench for multibyte_add_seq (NBYTES = 4).
// Build with +define+MULTIBYTE_ADD_SUB_EN to also exercise subtraction.
module tb_multibyte_add_seq;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;
  int   lat;

  multibyte_add_seq_if #(.NBYTES(NBYTES)) bus ();

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and let it be accepted on the next rising edge
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef MULTIBYTE_ADD_SUB_EN
    bus.sub   = sub;
`else
    if (sub) $display("[TB] note: sub requested without subtract support");
`endif
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; reports cycles counted after the accept edge
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  // Full operation: accept, wait for done, check result and one-cycle pulse
  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic [W-1:0] expSum,
                       input logic expCout, input logic expOvf);
    applyStimulus(a, b, cin, sub);
    checkOutput({tag, " busy"}, 64'(bus.busy), 64'd1);
    waitDone(lat);
    checkOutput({tag, " latency"}, 64'(lat), 64'(NBYTES));
    checkOutput({tag, " sum"}, 64'(bus.sum), 64'(expSum));
    checkOutput({tag, " cout"}, 64'(bus.cout), 64'(expCout));
    checkOutput({tag, " ovf"}, 64'(bus.ovf), 64'(expOvf));
    checkOutput({tag, " busy at done"}, 64'(bus.busy), 64'd0);
    tick();
    checkOutput({tag, " done pulse"}, 64'(bus.done), 64'd0);
    checkOutput({tag, " sum held"}, 64'(bus.sum), 64'(expSum));
  endtask

  // Main directed sequence
  initial begin
    assertCount = 0;
    failCount   = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef MULTIBYTE_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset sum", 64'(bus.sum), 64'd0);
    checkOutput("reset cout", 64'(bus.cout), 64'd0);
    checkOutput("reset ovf", 64'(bus.ovf), 64'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of an operation, after two bytes were stored
    applyStimulus(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("midrun partial sum", 64'(bus.sum), 64'h0000_0202);
    checkOutput("midrun busy", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrun reset busy", 64'(bus.busy), 64'd0);
    checkOutput("midrun reset sum", 64'(bus.sum), 64'd0);
    checkOutput("midrun reset done", 64'(bus.done), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic additions and carry/overflow corner cases
    runOp("add small", 32'h0000_0012, 32'h0000_0034, 1'b0, 1'b0, 32'h0000_0046, 1'b0, 1'b0);
    runOp("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    runOp("add ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // Start while busy is ignored; start held in the done cycle is accepted
    applyStimulus(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    tick();
    bus.a     = 32'hAAAA_AAAA;
    bus.b     = 32'h5555_5555;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("ignored start busy", 64'(bus.busy), 64'd1);
    tick();
    tick();
    checkOutput("first result done", 64'(bus.done), 64'd1);
    checkOutput("first result sum", 64'(bus.sum), 64'h3333_3333);
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    checkOutput("back-to-back done falls", 64'(bus.done), 64'd0);
    checkOutput("back-to-back busy", 64'(bus.busy), 64'd1);
    waitDone(lat);
    checkOutput("back-to-back latency", 64'(lat), 64'd4);
    checkOutput("back-to-back sum", 64'(bus.sum), 64'h0001_0001);
    checkOutput("back-to-back cout", 64'(bus.cout), 64'd0);
    tick();

`ifdef MULTIBYTE_ADD_SUB_EN
    // Subtraction: borrow and no-borrow cases
    runOp("sub borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runOp("sub noborrow", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
